// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter and its result FIFO.
package wb_arb_pkg;

   localparam int unsigned ARB_ADDR_W = 5;
   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } arb_state_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] rd;
      logic [ARB_DATA_W-1:0] data;
   } lu_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding long-latency unit results until a writeback slot is free.
module wb_result_fifo
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  lu_entry_t                i_wdata,
   input  logic                     i_pop,
   output lu_entry_t                o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   lu_entry_t      r_mem [DEPTH];
   logic           w_do_push;
   logic           w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback stage
// and buffered long-latency unit results, with starvation freeze and a busy scoreboard.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned DATA_W   = ARB_DATA_W,
   parameter int unsigned ADDR_W   = ARB_ADDR_W,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_reg_write_w,
   input  logic [ADDR_W-1:0]   i_rd_w,
   input  logic [DATA_W-1:0]   i_result_w,
   input  logic                i_lu_issue,
   input  logic [ADDR_W-1:0]   i_lu_issue_rd,
   input  logic                i_lu_valid,
   output logic                o_lu_ready,
   input  logic [ADDR_W-1:0]   i_lu_rd,
   input  logic [DATA_W-1:0]   i_lu_data,
   output logic                o_rf_we,
   output logic [ADDR_W-1:0]   o_rf_addr,
   output logic [DATA_W-1:0]   o_rf_wdata,
   output logic                o_stall_w,
   output logic [NUM_REGS-1:0] o_busy_mask
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [AGE_W-1:0] AGE_ONE   = 1;
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [AGE_W-1:0]    r_age;
   logic [AGE_W-1:0]    w_age_next;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;

   lu_entry_t           w_push_entry;
   lu_entry_t           w_head;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   logic                w_push;
   logic                w_pop;
   logic                w_pipe_wr;
   logic                w_empty_next;

   assign w_push_entry = '{rd: i_lu_rd, data: i_lu_data};
   assign o_lu_ready   = !w_full;
   assign w_push       = i_lu_valid && !w_full;
   assign w_pipe_wr    = i_reg_write_w && (i_rd_w != '0);
   // The pipeline owns the port unless we are draining; idle slots go to the FIFO head.
   assign w_pop        = !w_empty && ((r_state == DRAIN) || !w_pipe_wr);
   assign w_empty_next = !w_push && (w_empty || (w_pop && (w_count == CNT_ONE)));

   wb_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_wdata (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (!w_empty_next) begin
               w_state_next = WAIT;
            end
         end
         WAIT: begin
            if (w_empty_next) begin
               w_state_next = IDLE;
            end else if (!w_pop && (r_age == AGE_LIMIT)) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_empty_next) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_stall_w = (r_state == DRAIN);
   end

   always_comb begin
      w_age_next = '0;
      if ((r_state == WAIT) && (w_state_next == WAIT) && !w_pop) begin
         w_age_next = r_age + AGE_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_age <= '0;
      end else begin
         r_age <= w_age_next;
      end
   end

   always_comb begin
      o_rf_we    = 1'b0;
      o_rf_addr  = '0;
      o_rf_wdata = '0;
      if (w_pop) begin
         o_rf_we    = (w_head.rd != '0);
         o_rf_addr  = w_head.rd;
         o_rf_wdata = w_head.data;
      end else if (w_pipe_wr && (r_state != DRAIN)) begin
         o_rf_we    = 1'b1;
         o_rf_addr  = i_rd_w;
         o_rf_wdata = i_result_w;
      end
      // Entries being discarded by reset must not reach the register file.
      if (i_rst) begin
         o_rf_we = 1'b0;
      end
   end

   always_comb begin
      w_busy_next = r_busy;
      if (w_pop) begin
         w_busy_next[w_head.rd] = 1'b0;
      end
      if (i_lu_issue) begin
         w_busy_next[i_lu_issue_rd] = 1'b1;
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign o_busy_mask = r_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: directed vectors queue expected register-file writes, a monitor checks them.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reg_write_w = 1'b0;
   logic [4:0]  rd_w = '0;
   logic [31:0] result_w = '0;
   logic        lu_issue = 1'b0;
   logic [4:0]  lu_issue_rd = '0;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_rd = '0;
   logic [31:0] lu_data = '0;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic        stall_w;
   logic [31:0] busy_mask;

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_cnt  = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   wb_port_arbiter dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_reg_write_w (reg_write_w),
      .i_rd_w        (rd_w),
      .i_result_w    (result_w),
      .i_lu_issue    (lu_issue),
      .i_lu_issue_rd (lu_issue_rd),
      .i_lu_valid    (lu_valid),
      .o_lu_ready    (lu_ready),
      .i_lu_rd       (lu_rd),
      .i_lu_data     (lu_data),
      .o_rf_we       (rf_we),
      .o_rf_addr     (rf_addr),
      .o_rf_wdata    (rf_wdata),
      .o_stall_w     (stall_w),
      .o_busy_mask   (busy_mask)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h want %h", name, cyc_cnt, act, exp);
      end
   endtask

   // Monitor: every write the DUT presents must match the entry queued for this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missed_write cyc %0d: got none want rd %0d data %h", e.cyc, e.addr, e.data);
      end
      if (rf_we === 1'b1) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            check("rf_addr", 32'(rf_addr), 32'(e.addr));
            check("rf_wdata", rf_wdata, e.data);
         end else begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_write cyc %0d: got rd %0d data %h want no write",
                     cyc_cnt, rf_addr, rf_wdata);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_write cyc %0d: got rf_we=%b want rd %0d data %h",
                  cyc_cnt, rf_we, e.addr, e.data);
      end
      if (!rst && reg_write_w && rd_w != 5'd0 && busy_mask[rd_w] === 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL collision cyc %0d: got pipeline write to busy rd %0d want none",
                  cyc_cnt, rd_w);
      end
   end

   // One cycle of directed stimulus with hand-computed write, stall, ready and busy values.
   task automatic vec(input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic iss, input logic [4:0] issrd,
                      input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata,
                      input logic estall, input logic eready, input logic [31:0] ebusy);
      reg_write_w = rw;
      rd_w        = rdw;
      result_w    = resw;
      lu_valid    = lv;
      lu_rd       = lrd;
      lu_data     = ldat;
      lu_issue    = iss;
      lu_issue_rd = issrd;
      if (ewe) exp_q.push_back('{cyc: cyc_cnt, addr: eaddr, data: edata});
      @(negedge clk);
      check("stall_w", 32'(stall_w), 32'(estall));
      check("lu_ready", 32'(lu_ready), 32'(eready));
      check("busy_mask", busy_mask, ebusy);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rf_we", 32'(rf_we), 32'd0);
      check("reset_lu_ready", 32'(lu_ready), 32'd1);
      check("reset_stall_w", 32'(stall_w), 32'd0);
      check("reset_busy_mask", busy_mask, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle drain: LU result written the cycle after acceptance.
      vec(0, 0, 0,     1, 5, 32'hDEADBEEF, 1, 5,  0, 0, 0,            0, 1, 32'h0);
      vec(0, 0, 0,     0, 0, 0,            0, 0,  1, 5, 32'hDEADBEEF, 0, 1, 32'h20);

      // Starvation: four pipeline writes, then one frozen cycle for rd 7.
      vec(1, 3, 'h300, 1, 7, 'h11, 1, 7,  1, 3, 'h300, 0, 1, 32'h0);
      vec(1, 3, 'h301, 0, 0, 0,    0, 0,  1, 3, 'h301, 0, 1, 32'h80);
      vec(1, 3, 'h302, 0, 0, 0,    0, 0,  1, 3, 'h302, 0, 1, 32'h80);
      vec(1, 3, 'h303, 0, 0, 0,    0, 0,  1, 3, 'h303, 0, 1, 32'h80);
      vec(1, 3, 'h304, 0, 0, 0,    0, 0,  1, 3, 'h304, 0, 1, 32'h80);
      vec(1, 3, 'h305, 0, 0, 0,    0, 0,  1, 7, 'h11,  1, 1, 32'h80);
      vec(1, 3, 'h306, 0, 0, 0,    0, 0,  1, 3, 'h306, 0, 1, 32'h0);

      // Full FIFO: rd 10 waits for a DRAIN pop; writes in order 8, 9, 10.
      vec(1, 3, 'h310, 1, 8,  'h80, 0, 0,  1, 3,  'h310, 0, 1, 32'h0);
      vec(1, 3, 'h311, 1, 9,  'h90, 0, 0,  1, 3,  'h311, 0, 1, 32'h0);
      vec(1, 3, 'h312, 1, 10, 'hA0, 0, 0,  1, 3,  'h312, 0, 0, 32'h0);
      vec(1, 3, 'h313, 1, 10, 'hA0, 0, 0,  1, 3,  'h313, 0, 0, 32'h0);
      vec(1, 3, 'h314, 1, 10, 'hA0, 0, 0,  1, 3,  'h314, 0, 0, 32'h0);
      vec(1, 3, 'h315, 1, 10, 'hA0, 0, 0,  1, 8,  'h80,  1, 0, 32'h0);
      vec(1, 3, 'h316, 1, 10, 'hA0, 0, 0,  1, 9,  'h90,  1, 1, 32'h0);
      vec(1, 3, 'h317, 0, 0,  0,    0, 0,  1, 10, 'hA0,  1, 1, 32'h0);
      vec(1, 3, 'h318, 0, 0,  0,    0, 0,  1, 3,  'h318, 0, 1, 32'h0);

      // x0: LU entry for rd 0 pops silently; pipeline write to rd 0 suppressed.
      vec(0, 0, 0,    1, 0, 'hFF, 0, 0,  0, 0, 0, 0, 1, 32'h0);
      vec(0, 0, 0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 1, 32'h0);
      vec(1, 0, 'h55, 0, 0, 0,    0, 0,  0, 0, 0, 0, 1, 32'h0);
      vec(0, 0, 0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 1, 32'h0);

      // Reset while in DRAIN with two entries queued.
      vec(1, 3, 'h320, 1, 11, 'hB0, 1, 11,  1, 3, 'h320, 0, 1, 32'h0);
      vec(1, 3, 'h321, 1, 12, 'hC0, 1, 12,  1, 3, 'h321, 0, 1, 32'h800);
      vec(1, 3, 'h322, 0, 0,  0,    0, 0,   1, 3, 'h322, 0, 0, 32'h1800);
      vec(1, 3, 'h323, 0, 0,  0,    0, 0,   1, 3, 'h323, 0, 0, 32'h1800);
      vec(1, 3, 'h324, 0, 0,  0,    0, 0,   1, 3, 'h324, 0, 0, 32'h1800);
      rst = 1'b1;
      vec(0, 0, 0,     0, 0,  0,    0, 0,   0, 0, 0,     1, 0, 32'h1800);
      rst = 1'b0;
      vec(0, 0, 0,     0, 0,  0,    0, 0,   0, 0, 0,     0, 1, 32'h0);

      // Issue and pop of the same rd in one cycle: the set wins.
      vec(0, 0, 0, 1, 4, 'h44, 1, 4,  0, 0, 0,     0, 1, 32'h0);
      vec(0, 0, 0, 0, 0, 0,    1, 4,  1, 4, 'h44,  0, 1, 32'h10);
      vec(0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 0,     0, 1, 32'h10);
      vec(0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 0,     0, 1, 32'h10);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
